// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
// Holds the scan state encoding, the dark segment pattern and the pin polarity helper.
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF = 8'h00;

    function automatic logic [7:0] seg_pins(input logic [7:0] pattern, input logic active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit 7-segment driver with dead time, PWM brightness, per-digit blanking
// and a frame-synchronous double-buffered load.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SLOT_CYCLES    = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter int BRIGHT_W       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [8*NUM_DIGITS-1:0]   load_data,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [BRIGHT_W-1:0]       bright,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_start
);

    localparam int SLOT_W = $clog2(SLOT_CYCLES);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]     BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_IDLE    = AN_ACTIVE_LOW ? '1 : '0;

    scan_state_t                      state, state_nxt;
    logic [SLOT_W-1:0]                slot_cnt, slot_nxt;
    logic [IDX_W-1:0]                 idx, idx_nxt;
    logic [BRIGHT_W-1:0]              pwm_cnt, pwm_nxt;
    logic [NUM_DIGITS-1:0][7:0]       display_buf, pending_buf;
    logic                             pending_full;
    logic                             frame_end;
    logic                             pwm_on;
    logic [7:0]                       seg_int;
    logic [NUM_DIGITS-1:0]            an_int;

    assign frame_end  = (slot_cnt == SLOT_LAST) && (idx == IDX_LAST);
    assign load_ready = !pending_full;

    // Outputs are computed from the next-cycle scan position so the registered pins line up with the counters.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot_cnt + 1'b1;
        idx_nxt   = idx;
        pwm_nxt   = pwm_cnt + 1'b1;
        seg_int   = SEG_OFF;
        an_int    = '0;
        if (slot_cnt == SLOT_LAST) begin
            slot_nxt = '0;
            idx_nxt  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        case (state)
            BLANK:   if (slot_cnt == BLANK_LAST) state_nxt = DRIVE;
            DRIVE:   if (slot_cnt == SLOT_LAST)  state_nxt = BLANK;
            default: state_nxt = BLANK;
        endcase
        pwm_on = (bright == '1) || (pwm_nxt < bright);
        if (state_nxt == DRIVE) begin
            seg_int = display_buf[idx_nxt];
            if (!blank_mask[idx_nxt] && pwm_on) an_int[idx_nxt] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state    <= BLANK;
            slot_cnt <= '0;
            idx      <= '0;
            pwm_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            slot_cnt <= slot_nxt;
            idx      <= idx_nxt;
            pwm_cnt  <= pwm_nxt;
        end
    end

    // Commit only at the frame wrap; a capture can never coincide with a commit since they need opposite pending_full.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            display_buf  <= '0;
            pending_buf  <= '0;
            pending_full <= 1'b0;
        end else if (frame_end && pending_full) begin
            display_buf  <= pending_buf;
            pending_full <= 1'b0;
        end else if (load_valid && !pending_full) begin
            pending_buf  <= load_data;
            pending_full <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            seg         <= seg_pins(SEG_OFF, SEG_ACTIVE_LOW);
            an          <= AN_IDLE;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_pins(seg_int, SEG_ACTIVE_LOW);
            an          <= AN_ACTIVE_LOW ? ~an_int : an_int;
            frame_start <= frame_end;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: random frames checked cycle by cycle against a position-based reference model.
module tb_seven_seg_scan;

    localparam int N     = 4;
    localparam int SLOT  = 8;
    localparam int BLK   = 2;
    localparam int BW    = 2;
    localparam int FRAME = N * SLOT;

    logic             clock = 1'b0;
    logic             rst = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [8*N-1:0]   load_data = '0;
    logic [N-1:0]     blank_mask = '0;
    logic [BW-1:0]    bright = '1;
    logic [7:0]       seg;
    logic [N-1:0]     an;
    logic             frame_start;

    int tests_run = 0;
    int failed = 0;

    seven_seg_scan #(
        .NUM_DIGITS(N), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLK), .BRIGHT_W(BW),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clock), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .blank_mask(blank_mask), .bright(bright),
        .seg(seg), .an(an), .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    // Reference model: t is the number of clocks since reset release; everything else follows from it.
    int                 t;
    logic [N-1:0][7:0]  m_disp, m_pend;
    logic               m_full;
    logic [BW-1:0]      m_bright;
    logic [N-1:0]       m_mask;

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            t <= 0; m_disp <= '0; m_pend <= '0; m_full <= 1'b0; m_bright <= '0; m_mask <= '0;
        end else begin
            if ((t % FRAME) == FRAME - 1 && m_full) begin
                m_disp <= m_pend;
                m_full <= 1'b0;
            end else if (load_valid && !m_full) begin
                m_pend <= load_data;
                m_full <= 1'b1;
            end
            m_bright <= bright;
            m_mask   <= blank_mask;
            t        <= t + 1;
        end
    end

    // Expected {an, seg, frame_start, load_ready} for the current cycle.
    function automatic logic [13:0] expected();
        int w = t % SLOT;
        int d = (t / SLOT) % N;
        int p = t % (1 << BW);
        logic lit = (m_bright == '1) || (p < int'(m_bright));
        logic [N-1:0] a = '1;
        logic [7:0] s = 8'hFF;
        if (w >= BLK) begin
            s = ~m_disp[d];
            if (!m_mask[d] && lit) a[d] = 1'b0;
        end
        return {a, s, (t > 0) && (t % FRAME == 0), !m_full};
    endfunction

    task automatic test_reset();
        #1 rst = 1'b1;
        #11;
        tests_run++;
        if (an !== 4'hF || seg !== 8'hFF) begin
            failed++; $display("FAIL reset_pins an=%h seg=%h want an=f seg=ff", an, seg);
        end
        tests_run++;
        if (load_ready !== 1'b1 || frame_start !== 1'b0) begin
            failed++; $display("FAIL reset_ctrl ready=%b fs=%b want ready=1 fs=0", load_ready, frame_start);
        end
        @(negedge clock); rst = 1'b0;
        repeat (FRAME + 4) begin
            @(negedge clock); tests_run++;
            if ({an, seg, frame_start, load_ready} !== expected()) begin
                failed++; $display("FAIL reset_run t=%0d got %h want %h", t, {an, seg, frame_start, load_ready}, expected());
            end
        end
    endtask

    task automatic test_scan();
        int last_fs = -1;
        bright = 2'd3; blank_mask = '0;
        @(negedge clock); load_valid = 1'b1; load_data = 32'h08040201;
        @(negedge clock); load_valid = 1'b0;
        repeat (3 * FRAME) begin
            @(negedge clock); tests_run++;
            if ({an, seg, frame_start, load_ready} !== expected()) begin
                failed++; $display("FAIL scan t=%0d got %h want %h", t, {an, seg, frame_start, load_ready}, expected());
            end
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    tests_run++;
                    if (t - last_fs != FRAME) begin
                        failed++; $display("FAIL fs_period got %0d want %0d", t - last_fs, FRAME);
                    end
                end
                last_fs = t;
            end
        end
    endtask

    task automatic test_no_tearing();
        for (int k = 0; k < 2 * FRAME && (t % FRAME) != 10; k++) @(negedge clock);
        tests_run++;
        if ((t % FRAME) != 10) begin
            failed++; $display("FAIL tear_wait got %0d want 10", t % FRAME);
        end
        load_valid = 1'b1; load_data = $urandom();
        @(negedge clock);
        tests_run++;
        if (load_ready !== 1'b0) begin
            failed++; $display("FAIL tear_ready got %b want 0", load_ready);
        end
        load_data = $urandom();
        repeat (5) begin
            @(negedge clock); tests_run++;
            if ({an, seg, frame_start, load_ready} !== expected()) begin
                failed++; $display("FAIL tear_b t=%0d got %h want %h", t, {an, seg, frame_start, load_ready}, expected());
            end
        end
        load_valid = 1'b0;
        repeat (2 * FRAME) begin
            @(negedge clock); tests_run++;
            if ({an, seg, frame_start, load_ready} !== expected()) begin
                failed++; $display("FAIL tear t=%0d got %h want %h", t, {an, seg, frame_start, load_ready}, expected());
            end
        end
    endtask

    task automatic test_pwm();
        int lit_cycles = 0;
        bright = 2'd1;
        @(negedge clock); load_valid = 1'b1; load_data = $urandom();
        @(negedge clock); load_valid = 1'b0;
        repeat (2 * FRAME) begin
            @(negedge clock); tests_run++;
            if ({an, seg, frame_start, load_ready} !== expected()) begin
                failed++; $display("FAIL pwm1 t=%0d got %h want %h", t, {an, seg, frame_start, load_ready}, expected());
            end
        end
        for (int r = 0; r < 4; r++) begin
            bright = BW'($urandom_range(0, 3));
            repeat (FRAME) begin
                @(negedge clock); tests_run++;
                if ({an, seg, frame_start, load_ready} !== expected()) begin
                    failed++; $display("FAIL pwm_rand b=%0d t=%0d got %h want %h", bright, t, {an, seg, frame_start, load_ready}, expected());
                end
            end
        end
        bright = 2'd0;
        @(negedge clock);
        repeat (FRAME) begin
            @(negedge clock);
            if (an !== 4'hF) lit_cycles++;
        end
        tests_run++;
        if (lit_cycles != 0) begin
            failed++; $display("FAIL pwm_off lit_cycles=%0d want 0", lit_cycles);
        end
        bright = 2'd3;
    endtask

    task automatic test_blank_mask();
        blank_mask = 4'b0100;
        repeat (2 * FRAME) begin
            @(negedge clock); tests_run++;
            if ({an, seg, frame_start, load_ready} !== expected()) begin
                failed++; $display("FAIL mask t=%0d got %h want %h", t, {an, seg, frame_start, load_ready}, expected());
            end
        end
        for (int r = 0; r < 3; r++) begin
            blank_mask = N'($urandom());
            repeat (FRAME) begin
                @(negedge clock); tests_run++;
                if ({an, seg, frame_start, load_ready} !== expected()) begin
                    failed++; $display("FAIL mask_rand m=%b t=%0d got %h want %h", blank_mask, t, {an, seg, frame_start, load_ready}, expected());
                end
            end
        end
        blank_mask = '0;
    endtask

    task automatic test_boundary_load();
        for (int k = 0; k < 2 * FRAME && (t % FRAME) != FRAME - 1; k++) @(negedge clock);
        tests_run++;
        if ((t % FRAME) != FRAME - 1) begin
            failed++; $display("FAIL edge_wait got %0d want %0d", t % FRAME, FRAME - 1);
        end
        load_valid = 1'b1; load_data = $urandom();
        @(negedge clock); load_valid = 1'b0;
        tests_run++;
        if (load_ready !== 1'b0) begin
            failed++; $display("FAIL edge_ready got %b want 0", load_ready);
        end
        repeat (2 * FRAME + 8) begin
            @(negedge clock); tests_run++;
            if ({an, seg, frame_start, load_ready} !== expected()) begin
                failed++; $display("FAIL edge t=%0d got %h want %h", t, {an, seg, frame_start, load_ready}, expected());
            end
        end
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 2 * FRAME && (t % FRAME) != 5; k++) @(negedge clock);
        load_valid = 1'b1; load_data = $urandom();
        @(negedge clock); load_valid = 1'b0;
        for (int k = 0; k < 2 * FRAME && (t % SLOT) != 4; k++) @(negedge clock);
        tests_run++;
        if ({an, seg, frame_start, load_ready} !== expected()) begin
            failed++; $display("FAIL prerst t=%0d got %h want %h", t, {an, seg, frame_start, load_ready}, expected());
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (an !== 4'hF || seg !== 8'hFF || load_ready !== 1'b1) begin
            failed++; $display("FAIL async_rst an=%h seg=%h ready=%b want f ff 1", an, seg, load_ready);
        end
        @(negedge clock); rst = 1'b0;
        repeat (2 * FRAME) begin
            @(negedge clock); tests_run++;
            if ({an, seg, frame_start, load_ready} !== expected()) begin
                failed++; $display("FAIL postrst t=%0d got %h want %h", t, {an, seg, frame_start, load_ready}, expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_no_tearing();
        test_pwm();
        test_blank_mask();
        test_boundary_load();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at t=%0d", t);
        $fatal(1, "watchdog");
    end

endmodule
